// File: rtl/audio_ade_packer_pkg.sv
`default_nettype none
// ============================================================================
// Package   : audio_pkg
// Purpose   : Shared constants and helpers for the audio ADE packer slice.
//             - Default latch position, packet length and counter width.
//             - Bit positions of the 24-bit audio FIFO word.
//             - Helper function that builds the packed FIFO word.
// Revision  : 1.0 - initial release
// ============================================================================
package audio_pkg;

   // hcnt value inside horizontal blanking where the line's packet count is latched
   localparam logic [10:0] HLATCH_DEFAULT  = 11'd1447;
   // pixel cycles per ADE packet
   localparam int          PKT_LEN_DEFAULT = 32;
   // width of the per-line packet counter
   localparam int          CNT_W_DEFAULT   = 4;

   // Packed FIFO word layout: {vcnt, 4'd0, adin[11:4], adin[2]}
   localparam int FIFO_W      = 24;
   localparam int VCNT_MSB    = 23;
   localparam int VCNT_LSB    = 13;
   localparam int PAD_MSB     = 12;
   localparam int PAD_LSB     = 9;
   localparam int ADIN_HI_MSB = 8;
   localparam int ADIN_HI_LSB = 1;
   localparam int ADIN_B2_POS = 0;

   // Only the adin bits that are stored are passed in, so callers decide what
   // happens to the discarded bits.
   function automatic logic [FIFO_W-1:0] pack_word(
      input logic [10:0] vcnt,
      input logic [7:0]  adin_hi,
      input logic        adin_b2
   );
      logic [FIFO_W-1:0] w;
      w                           = '0;
      w[VCNT_MSB:VCNT_LSB]        = vcnt;
      w[PAD_MSB:PAD_LSB]          = '0;
      w[ADIN_HI_MSB:ADIN_HI_LSB]  = adin_hi;
      w[ADIN_B2_POS]              = adin_b2;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/audio_ade_packer_if.sv
`default_nettype none
// ============================================================================
// Interface : audio_ade_packer_if
// Purpose   : Write-side connection between the ADE packer and the audio
//             async FIFO.
// Signals   : fifo_wr_en  - write strobe (packer -> FIFO)
//             fifo_din    - 24-bit packed audio word (packer -> FIFO)
//             fifo_full   - FIFO full flag (FIFO -> packer)
// Modports  : master - packer side; slave - FIFO side
// Revision  : 1.0 - initial release
// ============================================================================
interface audio_ade_packer_if;
   import audio_pkg::*;

   logic              fifo_wr_en;
   logic [FIFO_W-1:0] fifo_din;
   logic              fifo_full;

   modport master (
      output fifo_wr_en,
      output fifo_din,
      input  fifo_full
   );

   modport slave (
      input  fifo_wr_en,
      input  fifo_din,
      output fifo_full
   );

endinterface
`default_nettype wire

// File: rtl/audio_ade_packer_ade_period_counter.sv
`default_nettype none
// ============================================================================
// Module    : ade_period_counter
// Purpose   : Counts PKT_LEN-cycle ADE packets within a line and latches the
//             count once per line.
// Ports     : clk        - pixel clock
//             rst_n      - asynchronous active-low reset
//             ainit_i    - counting enabled (armed by first video_en)
//             ade_i      - audio data enable
//             video_en_i - active-video indicator
//             vde_i      - video data enable
//             hcnt_i     - horizontal counter
//             ade_num_o  - packet count of the previous line
// Revision  : 1.0 - initial release
// ============================================================================
module ade_period_counter
   import audio_pkg::*;
#(
   parameter logic [10:0] HLATCH  = HLATCH_DEFAULT,
   parameter int          PKT_LEN = PKT_LEN_DEFAULT,
   parameter int          CNT_W   = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ainit_i,
   input  logic             ade_i,
   input  logic             video_en_i,
   input  logic             vde_i,
   input  logic [10:0]      hcnt_i,
   output logic [CNT_W-1:0] ade_num_o
);

   localparam int               PKT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [PKT_W-1:0] cnt_pkt_q, cnt_pkt_d;
   logic [CNT_W-1:0] ade_c_q,   ade_c_d;
   logic [CNT_W-1:0] ade_num_q, ade_num_d;
   logic             vde_d_q;
   logic             pkt_start;
   logic             latch_evt;

   always_comb begin
      pkt_start = ainit_i & ade_i & (cnt_pkt_q == '0);
      // Blanking position and vde rising edge share one latch; both at once
      // still act as a single event.
      latch_evt = ainit_i & ((~video_en_i & (hcnt_i == HLATCH)) |
                             (vde_i & ~vde_d_q));

      // Any gap in ade restarts the packet phase so packets resynchronise.
      cnt_pkt_d = '0;
      if (ade_i) begin
         cnt_pkt_d = (cnt_pkt_q == PKT_LAST) ? '0 : cnt_pkt_q + PKT_W'(1);
      end

      ade_c_d   = ade_c_q;
      ade_num_d = ade_num_q;
      if (pkt_start && (ade_c_q != CNT_MAX)) begin
         ade_c_d = ade_c_q + CNT_W'(1);
      end
      if (latch_evt) begin
         // A packet starting on the latch cycle belongs to the next line.
         ade_num_d = ade_c_q;
         ade_c_d   = pkt_start ? CNT_W'(1) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_pkt_q <= '0;
         ade_c_q   <= '0;
         ade_num_q <= '0;
         vde_d_q   <= 1'b0;
      end else begin
         cnt_pkt_q <= cnt_pkt_d;
         ade_c_q   <= ade_c_d;
         ade_num_q <= ade_num_d;
         vde_d_q   <= vde_i;
      end
   end

   assign ade_num_o = ade_num_q;

endmodule
`default_nettype wire

// File: rtl/audio_ade_packer.sv
`default_nettype none
// ============================================================================
// Module    : audio_ade_packer
// Purpose   : Qualifies HDMI audio data-enable periods, packs audio words into
//             the 24-bit async FIFO format and exports the per-line ADE packet
//             count.
// Ports     : rx0_pclk  - pixel clock
//             rstbtn_n  - asynchronous active-low reset
//             video_en  - active-video indicator
//             vde       - video data enable
//             ade       - audio data enable
//             adin      - 12-bit audio/aux data
//             hcnt/vcnt - horizontal / vertical counters
//             fifo      - FIFO write interface (master modport)
//             ade_num   - ADE packet count of the previous line
//             drop_cnt/drop_sticky - only with AUDIO_ADE_DROP_CNT_EN
// Options   : AUDIO_ADE_DROP_CNT_EN - adds a saturating count of writes
//             dropped on FIFO full plus a sticky drop flag.
// Revision  : 1.0 - initial release
// ============================================================================
module audio_ade_packer
   import audio_pkg::*;
#(
   parameter logic [10:0] HLATCH  = HLATCH_DEFAULT,
   parameter int          PKT_LEN = PKT_LEN_DEFAULT,
   parameter int          CNT_W   = CNT_W_DEFAULT
) (
   input  logic               rx0_pclk,
   input  logic               rstbtn_n,
   input  logic               video_en,
   input  logic               vde,
   input  logic               ade,
   input  logic [11:0]        adin,
   input  logic [10:0]        hcnt,
   input  logic [10:0]        vcnt,
   audio_ade_packer_if.master fifo,
   output logic [CNT_W-1:0]   ade_num
`ifdef AUDIO_ADE_DROP_CNT_EN
   ,
   output logic [15:0]        drop_cnt,
   output logic               drop_sticky
`endif
);

   logic              ainit_q;
   logic              wr_en_q;
   logic [FIFO_W-1:0] din_q;
   logic [FIFO_W-1:0] din_d;
   logic              wr_en_d;

   // adin[3] and adin[1:0] are not carried in the FIFO word.
   logic [2:0]        unused_adin;
   assign unused_adin = {adin[3], adin[1:0]};

   always_comb begin
      din_d   = pack_word(vcnt, adin[11:4], adin[2]);
      wr_en_d = ainit_q & ade & ~fifo.fifo_full;
   end

   always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         ainit_q <= 1'b0;
         wr_en_q <= 1'b0;
         din_q   <= '0;
      end else begin
         if (video_en) begin
            ainit_q <= 1'b1;
         end
         wr_en_q <= wr_en_d;
         din_q   <= din_d;
      end
   end

   assign fifo.fifo_wr_en = wr_en_q;
   assign fifo.fifo_din   = din_q;

   ade_period_counter #(
      .HLATCH  (HLATCH),
      .PKT_LEN (PKT_LEN),
      .CNT_W   (CNT_W)
   ) u_ade_period_counter (
      .clk        (rx0_pclk),
      .rst_n      (rstbtn_n),
      .ainit_i    (ainit_q),
      .ade_i      (ade),
      .video_en_i (video_en),
      .vde_i      (vde),
      .hcnt_i     (hcnt),
      .ade_num_o  (ade_num)
   );

`ifdef AUDIO_ADE_DROP_CNT_EN
   logic [15:0] drop_cnt_q;
   logic        drop_sticky_q;
   logic        drop_evt;

   assign drop_evt = ainit_q & ade & fifo.fifo_full;

   always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         drop_cnt_q    <= '0;
         drop_sticky_q <= 1'b0;
      end else if (drop_evt) begin
         if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
         drop_sticky_q <= 1'b1;
      end
   end

   assign drop_cnt    = drop_cnt_q;
   assign drop_sticky = drop_sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_ade_packer.sv
`default_nettype none
// ============================================================================
// Module    : tb_audio_ade_packer
// Purpose   : Self-checking bench for audio_ade_packer: table of ADE bursts
//             with expected write counts, packed words and latched packet
//             counts, plus hand-written arm, gap, simultaneous-latch and
//             mid-line reset sequences.
// Revision  : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_audio_ade_packer;
   import audio_pkg::*;

   logic        clk = 1'b0;
   logic        rstbtn_n;
   logic        video_en;
   logic        vde;
   logic        ade;
   logic [11:0] adin;
   logic [10:0] hcnt;
   logic [10:0] vcnt;
   logic [3:0]  ade_num;
`ifdef AUDIO_ADE_DROP_CNT_EN
   logic [15:0] drop_cnt;
   logic        drop_sticky;
`endif

   always #5 clk = ~clk;

   audio_ade_packer_if u_if ();

   audio_ade_packer u_dut (
      .rx0_pclk (clk),
      .rstbtn_n (rstbtn_n),
      .video_en (video_en),
      .vde      (vde),
      .ade      (ade),
      .adin     (adin),
      .hcnt     (hcnt),
      .vcnt     (vcnt),
      .fifo     (u_if),
      .ade_num  (ade_num)
`ifdef AUDIO_ADE_DROP_CNT_EN
      ,
      .drop_cnt    (drop_cnt),
      .drop_sticky (drop_sticky)
`endif
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          n_ade;
      logic [11:0] adin;
      logic [10:0] vcnt;
      logic        full;
      int          exp_wr;
      logic [23:0] exp_din;
      logic [3:0]  exp_num;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ade high for n cycles then one low cycle; counts writes and records the
   // word written on the final ade cycle.
   task automatic run_ade(input int n, output int writes, output logic [23:0] last_din);
      writes   = 0;
      last_din = '0;
      ade      = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         if (u_if.fifo_wr_en === 1'b1) writes++;
         last_din = u_if.fifo_din;
      end
      ade = 1'b0;
      tick();
      if (u_if.fifo_wr_en === 1'b1) writes++;
   endtask

   // blanking-position latch; ade_num is sampled right after the latch edge
   task automatic latch_hcnt(output logic [3:0] num);
      hcnt = 11'd1447;
      tick();
      num  = ade_num;
      hcnt = 11'd0;
      tick();
   endtask

   task automatic arm();
      video_en = 1'b1;
      tick();
      video_en = 1'b0;
      tick();
   endtask

   initial begin
      int          w;
      logic [23:0] d;
      logic [3:0]  num;

      vecs[0] = '{32,  12'hABC, 11'd100,   1'b0, 32,  24'h0C8157, 4'd1};
      vecs[1] = '{96,  12'h000, 11'd0,     1'b0, 96,  24'h000000, 4'd3};
      vecs[2] = '{640, 12'hFFF, 11'h7FF,   1'b0, 640, 24'hFFE1FF, 4'hF};
      vecs[3] = '{1,   12'h004, 11'd1,     1'b0, 1,   24'h002001, 4'd1};
      vecs[4] = '{33,  12'h010, 11'd2,     1'b0, 33,  24'h004002, 4'd2};
      vecs[5] = '{32,  12'h123, 11'd5,     1'b1, 0,   24'h00A024, 4'd1};

      rstbtn_n     = 1'b0;
      video_en     = 1'b0;
      vde          = 1'b0;
      ade          = 1'b0;
      adin         = 12'hABC;
      hcnt         = 11'd0;
      vcnt         = 11'd100;
      u_if.fifo_full = 1'b0;

      // reset held with ade toggling
      for (int i = 0; i < 6; i++) begin
         ade = ~ade;
         tick();
      end
      check("reset_wr_en", {31'd0, u_if.fifo_wr_en}, 32'd0);
      check("reset_din", {8'd0, u_if.fifo_din}, 32'd0);
      check("reset_ade_num", {28'd0, ade_num}, 32'd0);
`ifdef AUDIO_ADE_DROP_CNT_EN
      check("reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
      ade      = 1'b0;
      rstbtn_n = 1'b1;
      tick();

      // not armed yet: no writes, no latch
      run_ade(40, w, d);
      check("unarmed_writes", w, 32'd0);
      latch_hcnt(num);
      check("unarmed_ade_num", {28'd0, num}, 32'd0);

      arm();

      for (int v = 0; v < 6; v++) begin
         adin           = vecs[v].adin;
         vcnt           = vecs[v].vcnt;
         u_if.fifo_full = vecs[v].full;
         run_ade(vecs[v].n_ade, w, d);
         u_if.fifo_full = 1'b0;
         check($sformatf("vec%0d_writes", v), w, vecs[v].exp_wr);
         check($sformatf("vec%0d_din", v), {8'd0, d}, {8'd0, vecs[v].exp_din});
         latch_hcnt(num);
         check($sformatf("vec%0d_ade_num", v), {28'd0, num}, {28'd0, vecs[v].exp_num});
      end
`ifdef AUDIO_ADE_DROP_CNT_EN
      check("drop_cnt", {16'd0, drop_cnt}, 32'd32);
      check("drop_sticky", {31'd0, drop_sticky}, 32'd1);
`endif

      // gap resync: 10 on, 2 off, 32 on -> two packets
      run_ade(10, w, d);
      tick();
      run_ade(32, w, d);
      latch_hcnt(num);
      check("gap_ade_num", {28'd0, num}, 32'd2);

      // packet start coinciding with vde rising edge while ade_c=2
      run_ade(64, w, d);
      ade = 1'b1;
      vde = 1'b1;
      tick();
      check("simul_ade_num", {28'd0, ade_num}, 32'd2);
      ade = 1'b0;
      tick();
      latch_hcnt(num);
      check("simul_next_ade_num", {28'd0, num}, 32'd1);
      vde = 1'b0;
      tick();

      // asynchronous reset in the middle of an ADE burst
      adin = 12'hABC;
      vcnt = 11'd100;
      ade  = 1'b1;
      tick();
      tick();
      check("midline_wr_en_before", {31'd0, u_if.fifo_wr_en}, 32'd1);
      rstbtn_n = 1'b0;
      #1;
      check("midline_async_wr_en", {31'd0, u_if.fifo_wr_en}, 32'd0);
      check("midline_async_ade_num", {28'd0, ade_num}, 32'd0);
`ifdef AUDIO_ADE_DROP_CNT_EN
      check("midline_drop_sticky", {31'd0, drop_sticky}, 32'd0);
`endif
      ade = 1'b0;
      tick();
      rstbtn_n = 1'b1;
      tick();
      run_ade(32, w, d);
      check("rearm_needed_writes", w, 32'd0);
      arm();
      run_ade(32, w, d);
      check("rearmed_writes", w, 32'd32);
      latch_hcnt(num);
      check("rearmed_ade_num", {28'd0, num}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/audio_ade_packer.md
Name: audio_ade_packer

Overview:
- Pixel-clock-domain stage directly upstream of the audio async FIFO (afifo24) feeding gmii_tx.
- Qualifies HDMI audio data-enable (ADE) periods, packs each audio sample word into the 24-bit FIFO format, and counts 32-cycle ADE packets per line.
- Exports the per-line packet count ade_num, which gmii_tx carries in its audio frames.

Parameters:
- HLATCH, 11'd1447: hcnt value in horizontal blanking at which the line's packet count is latched.
- PKT_LEN, 32: pixel cycles per ADE packet.
- CNT_W, 4: width of the packet counter and of ade_num.

Ports:
- rx0_pclk  in  1  pixel clock; the only clock.
- rstbtn_n  in  1  reset, asynchronous, active-low.
- video_en  in  1  active-video indicator from tmds_timing.
- vde  in  1  video data enable.
- ade  in  1  audio data enable from the TMDS decoder.
- adin  in  12  audio/aux data bits from the decoder.
- hcnt  in  11  horizontal counter.
- vcnt  in  11  vertical counter.
- fifo_full  in  1  audio FIFO full flag.
- fifo_wr_en  out  1  audio FIFO write strobe.
- fifo_din  out  24  packed word: {vcnt, 4'd0, adin[11:4], adin[2]}.
- ade_num  out  CNT_W  ADE packet count of the previous line.

Behaviour:
- Reset (asynchronous, while rstbtn_n=0):
  - fifo_wr_en=0, fifo_din=0, ade_num=0.
  - Internal: ainit=0, cnt_pkt=0, ade_c=0, vde_d=0.
- ainit:
  - Set to 1 on the first cycle with video_en=1.
  - Stays 1 until reset.
  - While ainit=0: no FIFO writes, ade_c holds 0, ade_num holds 0.
- Write path, 1-cycle registered latency:
  - Next-cycle fifo_wr_en = ainit & ade & ~fifo_full.
  - fifo_din is registered from the same-cycle vcnt and adin.
  - When ade=1 and fifo_full=1, the write is dropped; the FIFO is never written while full.
- Intra-packet counter cnt_pkt, range 0..PKT_LEN-1:
  - While ade=1: increments and wraps from 31 to 0.
  - On any cycle with ade=0: resets to 0, so packets resynchronise after a gap.
- Packet counter ade_c:
  - Increments on cycles where ainit & ade & cnt_pkt==0.
  - Saturates at 4'hF; no wrap.
- Latch event L:
  - L = ainit & ((~video_en & hcnt==HLATCH) | (vde & ~vde_d)).
  - vde_d is vde registered.
  - On L: ade_num <= ade_c (visible the next cycle).
  - On L without a simultaneous packet start: ade_c <= 0.
  - On L coinciding with a packet start: ade_num takes the pre-increment ade_c, and ade_c <= 1, so the new packet counts toward the next line.
- Both L sources in the same cycle act as a single latch.
- Reset mid-line: all state clears immediately and counting resumes only after video_en re-arms ainit.

Optional Feature:
- Macro: AUDIO_ADE_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt[15:0], reset 0.
  - Increments, saturating at 16'hFFFF, on each cycle with ainit & ade & fifo_full.
  - Adds output drop_sticky, reset 0, set on the first drop and cleared only by reset.
- When undefined:
  - Neither port exists.
  - Drops are silent; all other behaviour is identical.

Decomposition:
- Shared package audio_pkg holds:
  - PKT_LEN and CNT_W defaults.
  - HLATCH default.
  - The packed-word field positions: vcnt [23:13], pad [12:9], adin[11:4] at [8:1], adin[2] at [0].
- One sub-module is natural: ade_period_counter, containing cnt_pkt, ade_c, the saturation logic, the latch logic and ade_num.
- The top level holds ainit, the write register and the optional drop counter.

Test Plan:
- Reset/arm: hold rstbtn_n=0 with ade=1 toggling → fifo_wr_en=0, ade_num=0. Release, ade pulses before any video_en → no writes.
- Single packet: after ainit, ade=1 for 32 cycles with adin=12'hABC, vcnt=100 → 32 writes of fifo_din=24'h0C8157. Then hcnt=1447 with video_en=0 → ade_num=1 the next cycle.
- Multi/saturation: 3 back-to-back packets (96 ade cycles) then latch → ade_num=3. 20 packets then latch → ade_num=15.
- Gap resync: ade=1 for 10 cycles, ade=0 for 2 cycles, ade=1 for 32 cycles, then latch → ade_num=2.
- Simultaneous: packet start in the same cycle as the vde rising edge, with ade_c=2 → ade_num=2, and the next latch with no further packets gives ade_num=1.
- Full: fifo_full=1 during 32 ade cycles → no fifo_wr_en. With AUDIO_ADE_DROP_CNT_EN defined → drop_cnt=32 and drop_sticky=1. ade_num still counts 1.
